segment_check_arbiter: RTL and testbench

Shared segment-limit check unit for the memory stage. Two requesters (read port 0, write port 1) share one pipelined limit-check datapath through a round-robin arbiter. The block holds the six programmable segment limit registers and returns a per-request fault flag two cycles after acceptance, with backpressure from the consumer.

---
 rtl/seg_check_pkg.sv | 45 ++++
 rtl/seg_limit_regfile.sv | 72 +++++++
 rtl/segment_check_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_segment_check_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_check_pkg.sv
// Shared constants for the segment-limit check unit: segment IDs, access-size
// codes, per-segment reset limits and default datapath widths.
package seg_check_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int LIMIT_W_DEF = 20;

   localparam logic [2:0] SEG_ES = 3'd0;
   localparam logic [2:0] SEG_CS = 3'd1;
   localparam logic [2:0] SEG_SS = 3'd2;
   localparam logic [2:0] SEG_DS = 3'd3;
   localparam logic [2:0] SEG_FS = 3'd4;
   localparam logic [2:0] SEG_GS = 3'd5;

   localparam logic [1:0] SIZE_1B = 2'd0;
   localparam logic [1:0] SIZE_2B = 2'd1;
   localparam logic [1:0] SIZE_4B = 2'd2;
   localparam logic [1:0] SIZE_8B = 2'd3;

   localparam logic [19:0] ES_LIMIT_RST = 20'h003ff;
   localparam logic [19:0] CS_LIMIT_RST = 20'h04fff;
   localparam logic [19:0] SS_LIMIT_RST = 20'h04000;
   localparam logic [19:0] DS_LIMIT_RST = 20'h011ff;
   localparam logic [19:0] FS_LIMIT_RST = 20'h003ff;
   localparam logic [19:0] GS_LIMIT_RST = 20'h007ff;

   typedef enum logic [0:0] {
      PORT_RD = 1'b0,
      PORT_WR = 1'b1
   } port_e;

   // Access length minus one, i.e. the offset of the last byte touched.
   function automatic logic [3:0] size_bytes_m1(input logic [1:0] size);
      logic [3:0] m1;
      case (size)
         SIZE_1B: m1 = 4'd0;
         SIZE_2B: m1 = 4'd1;
         SIZE_4B: m1 = 4'd3;
         SIZE_8B: m1 = 4'd7;
         default: m1 = 4'd0;
      endcase
      return m1;
   endfunction

endpackage

// File: rtl/seg_limit_regfile.sv
// Six segment limit registers, one write port and one combinational read port.
// Optional macro SEG_SS_CHECK_EN: when undefined, SS has no storage and is exempt.
module seg_limit_regfile
   import seg_check_pkg::*;
#(
   parameter int LIMIT_W = LIMIT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ld_v,
   input  logic [2:0]         ld_seg,
   input  logic [LIMIT_W-1:0] ld_limit,
   input  logic [2:0]         rd_seg,
   output logic [LIMIT_W-1:0] rd_limit,
   output logic               rd_exempt
);

   logic [LIMIT_W-1:0] es_r;
   logic [LIMIT_W-1:0] cs_r;
   logic [LIMIT_W-1:0] ds_r;
   logic [LIMIT_W-1:0] fs_r;
   logic [LIMIT_W-1:0] gs_r;
`ifdef SEG_SS_CHECK_EN
   logic [LIMIT_W-1:0] ss_r;
`endif

   // Limit storage: reset restores defaults, loads to IDs 6/7 fall through.
   always_ff @(posedge clk) begin
      if (rst) begin
         es_r <= LIMIT_W'(ES_LIMIT_RST);
         cs_r <= LIMIT_W'(CS_LIMIT_RST);
         ds_r <= LIMIT_W'(DS_LIMIT_RST);
         fs_r <= LIMIT_W'(FS_LIMIT_RST);
         gs_r <= LIMIT_W'(GS_LIMIT_RST);
`ifdef SEG_SS_CHECK_EN
         ss_r <= LIMIT_W'(SS_LIMIT_RST);
`endif
      end else if (ld_v) begin
         case (ld_seg)
            SEG_ES:  es_r <= ld_limit;
            SEG_CS:  cs_r <= ld_limit;
`ifdef SEG_SS_CHECK_EN
            SEG_SS:  ss_r <= ld_limit;
`endif
            SEG_DS:  ds_r <= ld_limit;
            SEG_FS:  fs_r <= ld_limit;
            SEG_GS:  gs_r <= ld_limit;
            default: ;
         endcase
      end
   end

   // Read port; an unchecked SS reports itself exempt instead of a limit.
   always_comb begin
      rd_limit  = '0;
      rd_exempt = 1'b0;
      case (rd_seg)
         SEG_ES:  rd_limit = es_r;
         SEG_CS:  rd_limit = cs_r;
`ifdef SEG_SS_CHECK_EN
         SEG_SS:  rd_limit = ss_r;
`else
         SEG_SS:  rd_exempt = 1'b1;
`endif
         SEG_DS:  rd_limit = ds_r;
         SEG_FS:  rd_limit = fs_r;
         SEG_GS:  rd_limit = gs_r;
         default: rd_limit = '0;
      endcase
   end

endmodule

// File: rtl/segment_check_arbiter.sv
// Round-robin shared segment-limit checker: arbiter, S1 check stage, S2 result stage.
// Optional macro SEG_SS_CHECK_EN enables limit checking of the SS segment.
module segment_check_arbiter
   import seg_check_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int LIMIT_W = LIMIT_W_DEF
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               LD_V,
   input  logic [2:0]         LD_SEG,
   input  logic [LIMIT_W-1:0] LD_LIMIT,
   input  logic               REQ0_V,
   input  logic [2:0]         REQ0_SEG,
   input  logic [ADDR_W-1:0]  REQ0_EA,
   input  logic [1:0]         REQ0_SIZE,
   input  logic               REQ1_V,
   input  logic [2:0]         REQ1_SEG,
   input  logic [ADDR_W-1:0]  REQ1_EA,
   input  logic [1:0]         REQ1_SIZE,
   output logic               GNT0,
   output logic               GNT1,
   output logic               RES_V,
   input  logic               RES_RDY,
   output logic               RES_ID,
   output logic [ADDR_W-1:0]  RES_EA,
   output logic               RES_EXC
);

   port_e              ptr_r;
   port_e              ptr_nxt_s;
   logic               gnt0_s;
   logic               gnt1_s;
   logic               accept_s;
   logic               s2_free_s;
   logic               s1_free_s;
   logic               s1_adv_s;

   logic               s1_v_r;
   logic [2:0]         s1_seg_r;
   logic [ADDR_W-1:0]  s1_ea_r;
   logic [1:0]         s1_size_r;
   logic               s1_id_r;

   logic [2:0]         in_seg_s;
   logic [ADDR_W-1:0]  in_ea_s;
   logic [1:0]         in_size_s;

   logic [LIMIT_W-1:0] rd_limit_s;
   logic               rd_exempt_s;
   logic [ADDR_W-1:0]  lim_ext_s;
   logic [ADDR_W-1:0]  bytes_m1_s;
   logic [ADDR_W-1:0]  bound_s;
   logic               borrow_s;
   logic               fault_s;

   logic               res_v_r;
   logic               res_id_r;
   logic [ADDR_W-1:0]  res_ea_r;
   logic               res_exc_r;

   // S1 may take a new request whenever it is empty or moving into S2 this cycle.
   assign s2_free_s = !res_v_r || RES_RDY;
   assign s1_adv_s  = s1_v_r && s2_free_s;
   assign s1_free_s = !s1_v_r || s2_free_s;

   // Round-robin grant and pointer next-state; only a contested grant flips PTR.
   always_comb begin
      gnt0_s    = 1'b0;
      gnt1_s    = 1'b0;
      ptr_nxt_s = ptr_r;
      if (!RST && s1_free_s) begin
         if (REQ0_V && REQ1_V) begin
            if (ptr_r == PORT_RD) begin
               gnt0_s    = 1'b1;
               ptr_nxt_s = PORT_WR;
            end else begin
               gnt1_s    = 1'b1;
               ptr_nxt_s = PORT_RD;
            end
         end else if (REQ0_V) begin
            gnt0_s = 1'b1;
         end else if (REQ1_V) begin
            gnt1_s = 1'b1;
         end else begin
            ptr_nxt_s = ptr_r;
         end
      end else begin
         ptr_nxt_s = ptr_r;
      end
   end

   assign GNT0     = gnt0_s;
   assign GNT1     = gnt1_s;
   assign accept_s = gnt0_s || gnt1_s;

   // Arbitration pointer register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_r <= PORT_RD;
      end else begin
         ptr_r <= ptr_nxt_s;
      end
   end

   // Select the granted requester's fields for S1.
   always_comb begin
      in_seg_s  = REQ0_SEG;
      in_ea_s   = REQ0_EA;
      in_size_s = REQ0_SIZE;
      if (gnt1_s) begin
         in_seg_s  = REQ1_SEG;
         in_ea_s   = REQ1_EA;
         in_size_s = REQ1_SIZE;
      end else begin
         in_seg_s  = REQ0_SEG;
         in_ea_s   = REQ0_EA;
         in_size_s = REQ0_SIZE;
      end
   end

   // S1 check stage register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_v_r    <= 1'b0;
         s1_seg_r  <= 3'd0;
         s1_ea_r   <= '0;
         s1_size_r <= 2'd0;
         s1_id_r   <= 1'b0;
      end else if (accept_s) begin
         s1_v_r    <= 1'b1;
         s1_seg_r  <= in_seg_s;
         s1_ea_r   <= in_ea_s;
         s1_size_r <= in_size_s;
         s1_id_r   <= gnt1_s;
      end else if (s1_adv_s) begin
         s1_v_r <= 1'b0;
      end
   end

   seg_limit_regfile #(
      .LIMIT_W (LIMIT_W)
   ) u_regfile (
      .clk       (CLK),
      .rst       (RST),
      .ld_v      (LD_V),
      .ld_seg    (LD_SEG),
      .ld_limit  (LD_LIMIT),
      .rd_seg    (s1_seg_r),
      .rd_limit  (rd_limit_s),
      .rd_exempt (rd_exempt_s)
   );

   // The last byte must not pass the limit; a borrow means even offset 0 fails.
   always_comb begin
      lim_ext_s             = ADDR_W'(rd_limit_s);
      bytes_m1_s            = ADDR_W'(size_bytes_m1(s1_size_r));
      {borrow_s, bound_s}   = {1'b0, lim_ext_s} - {1'b0, bytes_m1_s};
      if (s1_seg_r > SEG_GS) begin
         fault_s = 1'b1;
      end else if (rd_exempt_s) begin
         fault_s = 1'b0;
      end else begin
         fault_s = borrow_s || (s1_ea_r > bound_s);
      end
   end

   // S2 result stage: loads from S1, otherwise drains on handshake.
   always_ff @(posedge CLK) begin
      if (RST) begin
         res_v_r   <= 1'b0;
         res_id_r  <= 1'b0;
         res_ea_r  <= '0;
         res_exc_r <= 1'b0;
      end else if (s1_adv_s) begin
         res_v_r   <= 1'b1;
         res_id_r  <= s1_id_r;
         res_ea_r  <= s1_ea_r;
         res_exc_r <= fault_s;
      end else if (RES_RDY) begin
         res_v_r <= 1'b0;
      end
   end

   assign RES_V   = res_v_r;
   assign RES_ID  = res_id_r;
   assign RES_EA  = res_ea_r;
   assign RES_EXC = res_exc_r;

endmodule

// File: tb/tb_segment_check_arbiter.sv
// Scoreboard bench for segment_check_arbiter; honours SEG_SS_CHECK_EN like the RTL.
module tb_segment_check_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        LD_V;
   logic [2:0]  LD_SEG;
   logic [19:0] LD_LIMIT;
   logic        REQ0_V, REQ1_V;
   logic [2:0]  REQ0_SEG, REQ1_SEG;
   logic [31:0] REQ0_EA, REQ1_EA;
   logic [1:0]  REQ0_SIZE, REQ1_SIZE;
   logic        GNT0, GNT1;
   logic        RES_V, RES_RDY, RES_ID, RES_EXC;
   logic [31:0] RES_EA;

   typedef struct packed {
      logic        id;
      logic [31:0] ea;
      logic        exc;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_grants = 0;
   logic [19:0] mlim[6];
   logic        hold_v = 1'b0;
   exp_t        hold_val;

`ifdef SEG_SS_CHECK_EN
   localparam logic [19:0] SS_RST_TB = 20'h04000;
   localparam logic        SS_EXP    = 1'b1;
`else
   localparam logic [19:0] SS_RST_TB = 20'h00000;
   localparam logic        SS_EXP    = 1'b0;
`endif

   segment_check_arbiter dut (
      .CLK(CLK), .RST(RST), .LD_V(LD_V), .LD_SEG(LD_SEG), .LD_LIMIT(LD_LIMIT),
      .REQ0_V(REQ0_V), .REQ0_SEG(REQ0_SEG), .REQ0_EA(REQ0_EA), .REQ0_SIZE(REQ0_SIZE),
      .REQ1_V(REQ1_V), .REQ1_SEG(REQ1_SEG), .REQ1_EA(REQ1_EA), .REQ1_SIZE(REQ1_SIZE),
      .GNT0(GNT0), .GNT1(GNT1), .RES_V(RES_V), .RES_RDY(RES_RDY), .RES_ID(RES_ID),
      .RES_EA(RES_EA), .RES_EXC(RES_EXC)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_exc(input logic [2:0] seg, input logic [31:0] ea,
                                      input logic [1:0] size, input logic [19:0] lim);
      longint last;
      if (seg > 3'd5) return 1'b1;
`ifndef SEG_SS_CHECK_EN
      if (seg == 3'd2) return 1'b0;
`endif
      last = longint'(lim) - ((longint'(1) << size) - 1);
      if (last < 0) return 1'b1;
      return longint'({32'd0, ea}) > last;
   endfunction

   function automatic logic [19:0] eff_lim(input logic [2:0] seg);
      if (seg > 3'd5) return 20'd0;
      if (LD_V && LD_SEG == seg) return LD_LIMIT;
      return mlim[seg];
   endfunction

   task automatic restore_model();
      mlim[0] = 20'h003ff; mlim[1] = 20'h04fff; mlim[2] = SS_RST_TB;
      mlim[3] = 20'h011ff; mlim[4] = 20'h003ff; mlim[5] = 20'h007ff;
   endtask

   // Monitor: stability under stall, pop on handshake, push on grant, track loads.
   always @(negedge CLK) begin
      if (RST) begin
         sb.delete();
         hold_v = 1'b0;
         restore_model();
      end else begin
         if (hold_v) begin
            check_eq("stall_res_v", RES_V, 1'b1);
            check_eq("stall_hold", {RES_ID, RES_EA, RES_EXC}, hold_val);
         end
         hold_v   = RES_V && !RES_RDY;
         hold_val = {RES_ID, RES_EA, RES_EXC};
         if (RES_V && RES_RDY) begin
            if (sb.size() == 0) begin
               check_eq("sb_unexpected", 1'b1, 1'b0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_eq("res_id", RES_ID, e.id);
               check_eq("res_ea", RES_EA, e.ea);
               check_eq("res_exc", RES_EXC, e.exc);
            end
         end
         if (REQ0_V && GNT0) begin
            sb.push_back({1'b0, REQ0_EA, model_exc(REQ0_SEG, REQ0_EA, REQ0_SIZE, eff_lim(REQ0_SEG))});
            n_grants++;
         end
         if (REQ1_V && GNT1) begin
            sb.push_back({1'b1, REQ1_EA, model_exc(REQ1_SEG, REQ1_EA, REQ1_SIZE, eff_lim(REQ1_SEG))});
            n_grants++;
         end
         if (LD_V && LD_SEG <= 3'd5) mlim[LD_SEG] = LD_LIMIT;
      end
   end

   task automatic send(input logic port, input logic [2:0] seg, input logic [31:0] ea,
                       input logic [1:0] size, output int tries);
      logic g;
      g = 1'b0;
      tries = 0;
      if (port) begin
         REQ1_V = 1'b1; REQ1_SEG = seg; REQ1_EA = ea; REQ1_SIZE = size;
      end else begin
         REQ0_V = 1'b1; REQ0_SEG = seg; REQ0_EA = ea; REQ0_SIZE = size;
      end
      while (!g && tries < 20) begin
         @(negedge CLK);
         g = port ? GNT1 : GNT0;
         tries++;
         @(posedge CLK); #1;
      end
      REQ0_V = 1'b0;
      REQ1_V = 1'b0;
      if (!g) check_eq("grant_timeout", 1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      idle(2);
      RST = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   t;
      logic g;
      logic [31:0] ea;
      RST = 1'b1; LD_V = 1'b0; LD_SEG = 3'd0; LD_LIMIT = 20'd0;
      REQ0_V = 1'b1; REQ0_SEG = 3'd3; REQ0_EA = 32'd0; REQ0_SIZE = 2'd0;
      REQ1_V = 1'b1; REQ1_SEG = 3'd3; REQ1_EA = 32'd0; REQ1_SIZE = 2'd0;
      RES_RDY = 1'b1;
      idle(2);
      @(negedge CLK);
      check_eq("rst_gnt", {GNT0, GNT1}, 2'b00);
      check_eq("rst_res", {RES_V, RES_ID, RES_EA, RES_EXC}, 35'd0);
      @(posedge CLK); #1;
      RST = 1'b0; REQ0_V = 1'b0; REQ1_V = 1'b0;

      // DS limit 0x11ff: 4-byte access at 0x11fc is the last legal one.
      send(1'b0, 3'd3, 32'h000011fc, 2'd2, t);
      check_eq("t1_gnt_first", t, 1);
      @(negedge CLK);
      check_eq("t1_lat_n1", RES_V, 1'b0);
      @(negedge CLK);
      check_eq("t1_lat_n2", RES_V, 1'b1);
      check_eq("t1_exc", RES_EXC, 1'b0);
      send(1'b0, 3'd3, 32'h000011fd, 2'd2, t);
      idle(1); @(negedge CLK);
      check_eq("t1b_exc", RES_EXC, 1'b1);

      send(1'b0, 3'd7, 32'h00000000, 2'd0, t);
      idle(1); @(negedge CLK);
      check_eq("seg7_exc", RES_EXC, 1'b1);

      // ES limit 2 with an 8-byte access borrows.
      LD_V = 1'b1; LD_SEG = 3'd0; LD_LIMIT = 20'h00002;
      idle(1); LD_V = 1'b0;
      send(1'b0, 3'd0, 32'h00000000, 2'd3, t);
      idle(1); @(negedge CLK);
      check_eq("borrow_exc", RES_EXC, 1'b1);

      // Load while the request sits in S1: old limit (2) applies.
      send(1'b0, 3'd0, 32'h00000015, 2'd0, t);
      LD_V = 1'b1; LD_SEG = 3'd0; LD_LIMIT = 20'h00010;
      idle(1); LD_V = 1'b0;
      @(negedge CLK);
      check_eq("ld_old_exc", RES_EXC, 1'b1);
      send(1'b0, 3'd0, 32'h00000015, 2'd0, t);
      idle(1); @(negedge CLK);
      check_eq("ld_new_exc", RES_EXC, 1'b1);
      send(1'b0, 3'd0, 32'h00000010, 2'd0, t);
      idle(1); @(negedge CLK);
      check_eq("ld_edge_exc", RES_EXC, 1'b0);

      send(1'b1, 3'd2, 32'hffffff00, 2'd3, t);
      idle(1); @(negedge CLK);
      check_eq("ss_id", RES_ID, 1'b1);
      check_eq("ss_exc", RES_EXC, SS_EXP);
      idle(2);

      // Contested requests right after reset alternate starting with port 0.
      do_reset();
      REQ0_SEG = 3'd3; REQ0_EA = 32'h00000100; REQ0_SIZE = 2'd0;
      REQ1_SEG = 3'd1; REQ1_EA = 32'h00000200; REQ1_SIZE = 2'd1;
      for (int k = 0; k < 6; k++) begin
         REQ0_V = (k < 4); REQ1_V = (k < 4);
         @(negedge CLK);
         if (k < 4) begin
            check_eq("arb_gnt0", GNT0, (k % 2) == 0);
            check_eq("arb_gnt1", GNT1, (k % 2) == 1);
         end
         if (k >= 2) check_eq("arb_res_v", RES_V, 1'b1);
         @(posedge CLK); #1;
      end

      // Stall: three cycles with RES_RDY low against a continuous requester.
      t = n_grants;
      ea = 32'h00000400;
      REQ0_V = 1'b1; REQ0_SEG = 3'd3; REQ0_EA = ea; REQ0_SIZE = 2'd2;
      RES_RDY = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (k == 3) begin
            check_eq("stall_grants", n_grants - t, 2);
            RES_RDY = 1'b1;
         end
         @(negedge CLK);
         g = GNT0;
         if (k == 2) check_eq("stall_no_gnt", GNT0, 1'b0);
         if (k == 3) check_eq("release_gnt", GNT0, 1'b1);
         @(posedge CLK); #1;
         if (g) begin ea = ea + 32'd4; REQ0_EA = ea; end
      end
      REQ0_V = 1'b0;
      idle(5);
      check_eq("stall_drain", sb.size(), 0);

      // Reset with both stages full drops everything in flight.
      RES_RDY = 1'b0;
      REQ0_V = 1'b1;
      idle(3);
      RST = 1'b1; RES_RDY = 1'b1;
      @(negedge CLK);
      check_eq("rst_full_gnt", GNT0, 1'b0);
      @(posedge CLK); #1;
      RST = 1'b0; REQ0_V = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check_eq("rst_flush_v", RES_V, 1'b0);
      end

      idle(3);
      check_eq("sb_drain", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
